// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: issue bus between decode (master) and the hazard controller (slave)
interface pipe_hazard_ctrl_if #(parameter int AW = 3, parameter int FW = 3);
  logic in_valid, in_ready, in_use_a, in_use_b, in_we, in_is_load, stall;
  logic [AW-1:0] in_src_a, in_src_b, in_dst;
  logic [FW-1:0] fwd_a, fwd_b;
  modport master (
    output in_valid, in_src_a, in_src_b, in_use_a, in_use_b, in_dst, in_we, in_is_load,
    input  in_ready, stall, fwd_a, fwd_b
  );
  modport slave (
    input  in_valid, in_src_a, in_src_b, in_use_a, in_use_b, in_dst, in_we, in_is_load,
    output in_ready, stall, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: tag tracking, forwarding selects, load-use stall and flush kill; PIPE_HAZARD_STATS_EN adds stall/bubble counters
module pipe_hazard_ctrl #(
  parameter int DEPTH        = 4,
  parameter int AW           = 3,
  parameter int LOAD_STAGE   = 2,
  parameter int FLUSH_STAGES = 1,
  parameter int FW           = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pipe_en,
  input  logic                flush,
  pipe_hazard_ctrl_if.slave   dec,
  output logic [DEPTH-1:0]    stage_valid,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         bubble_cnt
);
  logic [DEPTH-1:0]         v, we, ld;
  logic [DEPTH-1:0][AW-1:0] dst;
  logic [FW-1:0]            fa, fb;
  logic                     la, lb, stall, accept;
  // scan oldest to youngest so the youngest match overrides
  always_comb begin
    fa = '0;
    fb = '0;
    la = 1'b0;
    lb = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (v[i] && we[i] && dec.in_use_a && dst[i] == dec.in_src_a) begin
        fa = FW'(i+1);
        la = ld[i] && (i+1 < LOAD_STAGE);
      end
      if (v[i] && we[i] && dec.in_use_b && dst[i] == dec.in_src_b) begin
        fb = FW'(i+1);
        lb = ld[i] && (i+1 < LOAD_STAGE);
      end
    end
  end
  assign stall        = dec.in_valid && (la || lb);
  assign dec.stall    = stall;
  assign dec.fwd_a    = fa;
  assign dec.fwd_b    = fb;
  assign dec.in_ready = pipe_en && !stall && !flush;
  assign accept       = dec.in_valid && dec.in_ready;
  assign stage_valid  = v;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v   <= '0;
      we  <= '0;
      ld  <= '0;
      dst <= '0;
    end else if (pipe_en) begin
      v[0]   <= accept;
      we[0]  <= dec.in_we;
      ld[0]  <= dec.in_is_load;
      dst[0] <= dec.in_dst;
      for (int k = 1; k < DEPTH; k++) begin
        v[k]   <= v[k-1] && !(flush && k <= FLUSH_STAGES);
        we[k]  <= we[k-1];
        ld[k]  <= ld[k-1];
        dst[k] <= dst[k-1];
      end
    end
`ifdef PIPE_HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (pipe_en) begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 16'd1;
      if (!accept && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 16'd1;
    end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus against a stage-array reference model
module tb_pipe_hazard_ctrl;
  localparam int DEPTH = 4, AW = 3, LS = 2, FS = 1, FW = 3;
`ifdef PIPE_HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct {bit v; bit we; bit ld; bit [AW-1:0] dst;} tag_t;

  logic clk = 1'b0, reset = 1'b0, pipe_en = 1'b1, flush = 1'b0;
  logic [DEPTH-1:0] stage_valid;
  logic [15:0] stall_cnt, bubble_cnt;
  pipe_hazard_ctrl_if #(.AW(AW), .FW(FW)) dec ();

  pipe_hazard_ctrl #(.DEPTH(DEPTH), .AW(AW), .LOAD_STAGE(LS), .FLUSH_STAGES(FS)) dut (
    .clk(clk), .reset(reset), .pipe_en(pipe_en), .flush(flush), .dec(dec),
    .stage_valid(stage_valid), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int vec = 0, err = 0;
  tag_t m [1:DEPTH];
  int sc = 0, bc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find(input logic [AW-1:0] s, input bit u);
    for (int k = 1; k <= DEPTH; k++)
      if (u && m[k].v && m[k].we && m[k].dst == s) return k;
    return 0;
  endfunction

  function automatic logic [DEPTH-1:0] mvalid();
    logic [DEPTH-1:0] r;
    for (int k = 1; k <= DEPTH; k++) r[k-1] = m[k].v;
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 1; k <= DEPTH; k++) m[k] = '{1'b0, 1'b0, 1'b0, '0};
    sc = 0;
    bc = 0;
  endtask

  task automatic drive(input bit en, val, input logic [AW-1:0] sa, input bit ua,
                       input logic [AW-1:0] sb, input bit ub, input logic [AW-1:0] d,
                       input bit w, ldi, fl);
    pipe_en = en; flush = fl; dec.in_valid = val;
    dec.in_src_a = sa; dec.in_use_a = ua; dec.in_src_b = sb; dec.in_use_b = ub;
    dec.in_dst = d; dec.in_we = w; dec.in_is_load = ldi;
  endtask

  task automatic step(input bit en, val, input logic [AW-1:0] sa, input bit ua,
                      input logic [AW-1:0] sb, input bit ub, input logic [AW-1:0] d,
                      input bit w, ldi, fl);
    int ka, kb;
    bit hz, st_e, rdy, acc;
    tag_t nx [1:DEPTH];
    drive(en, val, sa, ua, sb, ub, d, w, ldi, fl);
    #1;
    ka = find(sa, ua);
    kb = find(sb, ub);
    hz = (ka != 0 && m[ka].ld && ka < LS) || (kb != 0 && m[kb].ld && kb < LS);
    st_e = val && hz;
    rdy = en && !st_e && !fl;
    acc = val && rdy;
    chk("stall", dec.stall, st_e);
    chk("in_ready", dec.in_ready, rdy);
    chk("fwd_a", dec.fwd_a, ka);
    chk("fwd_b", dec.fwd_b, kb);
    chk("stage_valid", stage_valid, mvalid());
    chk("stall_cnt", stall_cnt, STATS ? sc : 0);
    chk("bubble_cnt", bubble_cnt, STATS ? bc : 0);
    nx = m;
    if (en) begin
      nx[1] = acc ? '{1'b1, w, ldi, d} : '{1'b0, 1'b0, 1'b0, '0};
      for (int k = 2; k <= DEPTH; k++)
        nx[k] = (fl && k-1 <= FS) ? '{1'b0, 1'b0, 1'b0, '0} : m[k-1];
    end
    @(posedge clk);
    m = nx;
    if (en) begin
      if (st_e && sc < 65535) sc++;
      if (!acc && bc < 65535) bc++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_valid", stage_valid, 0);
    chk("rst_stall", dec.stall, 0);
    chk("rst_fwd_a", dec.fwd_a, 0);
    chk("rst_ready", dec.in_ready, 1);
    flush = 1'b1;
    #1 chk("rst_ready_fl", dec.in_ready, 0);
    flush = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // RAW from EX, then youngest-wins with both we settings
    step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    step(1, 1, 3, 1, 0, 0, 5, 1, 0, 0);
    step(1, 1, 0, 0, 5, 1, 5, 1, 0, 0);
    step(1, 1, 0, 0, 5, 1, 5, 0, 0, 0);
    step(1, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    // load-use from an empty pipe
    idle(DEPTH);
    step(1, 1, 0, 0, 0, 0, 2, 1, 1, 0);
    drive(1, 1, 2, 1, 0, 0, 4, 1, 0, 0);
    #1;
    chk("lu_stall", dec.stall, 1);
    chk("lu_ready", dec.in_ready, 0);
    step(1, 1, 2, 1, 0, 0, 4, 1, 0, 0);
    #1;
    chk("lu_bubble_sv", stage_valid, 4'b0010);
    chk("lu_fwd_a", dec.fwd_a, 2);
    chk("lu_nostall", dec.stall, 0);
    step(1, 1, 2, 1, 0, 0, 4, 1, 0, 0);
    // flush with stages 1..3 valid
    idle(DEPTH);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 3'(i), 1, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 6, 1, 0, 1);
    #1 chk("fl_ready", dec.in_ready, 0);
    step(1, 1, 0, 0, 0, 0, 6, 1, 0, 1);
    idle(1);
    // flush together with a load-use stall
    step(1, 1, 0, 0, 0, 0, 2, 1, 1, 0);
    step(1, 1, 2, 1, 0, 0, 4, 1, 0, 1);
    // freeze
    step(1, 1, 0, 0, 0, 0, 7, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 7, 1, 7, 1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
    step(1, 1, 7, 1, 0, 0, 1, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(7) != 0, $urandom_range(3) != 0,
           3'($urandom), $urandom_range(1), 3'($urandom), $urandom_range(1),
           3'($urandom), $urandom_range(3) != 0, $urandom_range(2) == 0,
           $urandom_range(7) == 0);
    // asynchronous reset with a full pipe
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 0, 0, 3'(i), 1, 0, 0);
    #2 chk("pre_rst_sv", stage_valid, 4'b1111);
    reset = 1'b0;
    #1;
    chk("arst_valid", stage_valid, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_bubble_cnt", bubble_cnt, 0);
    chk("arst_fwd_b", dec.fwd_b, 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 200; i++)
      step(1, $urandom_range(1), 3'($urandom), 1, 3'($urandom), 1,
           3'($urandom), 1, $urandom_range(1), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
